// File: rtl/mem8x8_ctrl.sv
// Sequencing controller and two-requester arbiter for the 8x8 latch memory.
// Define MEM8X8_CTRL_PRIO_EN for fixed priority (req0 wins ties); default is round-robin.
module mem8x8_ctrl #(
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ACCESS_CYC = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0,
    input  logic                   req1,
    input  logic                   op0,
    input  logic                   op1,
    input  logic [ADDR_W-1:0]      addr0,
    input  logic [ADDR_W-1:0]      addr1,
    input  logic [DATA_W-1:0]      wdata0,
    input  logic [DATA_W-1:0]      wdata1,
    output logic                   ack0,
    output logic                   ack1,
    output logic [DATA_W-1:0]      rdata,
    output logic                   busy,
    output logic [2**ADDR_W-1:0]   mem_sel,
    output logic                   mem_op,
    output logic [DATA_W-1:0]      mem_inp,
    input  logic [DATA_W-1:0]      mem_outp
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned CNT_W = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              gnt;
    logic              grant1;

`ifdef MEM8X8_CTRL_PRIO_EN
    assign grant1 = req1 & ~req0;
`else
    logic last_grant;
    // On a tie, serve whichever requester was not served last.
    assign grant1 = req1 & (~req0 | ~last_grant);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            gnt     <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rdata   <= '0;
            busy    <= 1'b0;
            mem_sel <= '0;
            mem_op  <= 1'b0;
            mem_inp <= '0;
`ifndef MEM8X8_CTRL_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt     <= grant1;
                        mem_op  <= grant1 ? op1 : op0;
                        mem_inp <= grant1 ? wdata1 : wdata0;
                        addr_q  <= grant1 ? addr1 : addr0;
                        busy    <= 1'b1;
                        state   <= SETUP;
`ifndef MEM8X8_CTRL_PRIO_EN
                        last_grant <= grant1;
`endif
                    end
                end
                SETUP: begin
                    mem_sel <= {{(DEPTH-1){1'b0}}, 1'b1} << addr_q;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == CNT_W'(ACCESS_CYC - 1)) begin
                        mem_sel <= '0;
                        // Array output is still driven by the select on this edge.
                        if (!mem_op) begin
                            rdata <= mem_outp;
                        end
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    ack0  <= ~gnt;
                    ack1  <= gnt;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
